// File: rtl/hs_arith_gray_ptr_sync_if.sv
// Bus bundle for the Gray pointer synchroniser: foreign-domain pointer in,
// synchronised Gray/binary pointer and update/advance/integrity events out.
interface hs_arith_gray_ptr_sync_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din_gray;
  logic [WIDTH-1:0] dout_gray;
  logic [WIDTH-1:0] dout_bin;
  logic [WIDTH-1:0] adv;
  logic             upd;
  logic             err;
  logic             err_sticky;
  logic             err_clr;

  modport master (
    output din_gray, err_clr,
    input  dout_gray, dout_bin, adv, upd, err, err_sticky
  );

  modport slave (
    input  din_gray, err_clr,
    output dout_gray, dout_bin, adv, upd, err, err_sticky
  );
endinterface

// File: rtl/hs_arith_gray_ptr_sync.sv
// Resynchronises a foreign-domain Gray pointer, converts it to binary and
// reports per-step update, forward advance and Hamming-distance integrity.
module hs_arith_gray_ptr_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit CHECK_EN    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  hs_arith_gray_ptr_sync_if.slave  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("hs_arith_gray_ptr_sync: SYNC_STAGES must be 2..4");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("hs_arith_gray_ptr_sync: WIDTH must be 2..32");
  end

  // Pure flop chain, nothing combinational between stages.
  (* async_reg = "true" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.din_gray;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  logic [WIDTH-1:0] gray_cur;
  logic [WIDTH-1:0] bin_cur;
  assign gray_cur      = sync_q[SYNC_STAGES-1];
  assign bus.dout_gray = gray_cur;

  // Each binary bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign bin_cur[i] = ^gray_cur[WIDTH-1:i];
  end

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] adv_q;
  logic             upd_q;
  logic             changed;
  logic [WIDTH-1:0] adv_next;

  assign changed  = (gray_cur != gray_q);
  // bin_q always mirrors gray_q, so the difference is the step just taken.
  assign adv_next = changed ? (bin_cur - bin_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
      bin_q  <= '0;
      adv_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      gray_q <= gray_cur;
      bin_q  <= bin_cur;
      adv_q  <= adv_next;
      upd_q  <= changed;
    end
  end

  assign bus.dout_bin = bin_q;
  assign bus.adv      = adv_q;
  assign bus.upd      = upd_q;

  if (CHECK_EN) begin : g_check
    logic err_next;
    logic err_q;
    logic sticky_q;

    assign err_next = ($countones(gray_cur ^ gray_q) > 1);

    // A fresh error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        err_q    <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        err_q    <= err_next;
        sticky_q <= err_next | (sticky_q & ~bus.err_clr);
      end
    end

    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
  end else begin : g_nocheck
    assign bus.err        = 1'b0;
    assign bus.err_sticky = 1'b0;
  end

endmodule
